// File: rtl/pcpu_ctrl_pkg.sv
// Shared run-control definitions: state encoding and counter widths used by
// the run-control sequencer, the display mux and the CPU debug logic.
package pcpu_ctrl_pkg;

    // run_state encoding as seen on the seven-segment display
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } run_state_t;

    // Width of the executed-cycle counter
    localparam int CYCLE_W = 16;

    // Width of the debounce stability counter (covers DEBOUNCE_CYCLES up to 2^20-1)
    localparam int DEB_W = 20;

    // Width of the auto-mode prescaler (covers TICK_DIV up to 2^32-1)
    localparam int PRESC_W = 32;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: the accepted level follows the (already synchronized)
// input only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
// A rising edge of the accepted level yields a one-cycle press strobe that is
// registered together with the level change.
module btn_debounce
    import pcpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic press
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);

    logic [DEB_W-1:0] cnt_r;
    logic [DEB_W-1:0] cnt_s;
    logic             level_s;
    logic             press_s;

    // Next stability count, accepted level and press strobe
    always_comb begin
        cnt_s   = cnt_r;
        level_s = level;
        press_s = 1'b0;
        if (din != level) begin
            if (cnt_r >= CNT_LAST) begin
                level_s = din;
                cnt_s   = '0;
                press_s = din;
            end else begin
                cnt_s = cnt_r + CNT_ONE;
            end
        end else begin
            // any cycle of agreement restarts the stability window
            cnt_s = '0;
        end
    end

    // Debounce state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            cnt_r <= cnt_s;
            level <= level_s;
            press <= press_s;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: single-clock scheme that issues one-cycle CPU clock
// enables from a free-running prescaler (auto mode) or from debounced step
// presses (debug mode), generates the CPU start pulse, handles halt and
// counts issued enables for the display.
module cpu_run_ctrl
    import pcpu_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int          DEBOUNCE_CYCLES = 500_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               debug,
    input  logic               en,
    input  logic               m_clk_btn,
    input  logic               halt_req,
    output logic               cpu_ce,
    output logic               cpu_start,
    output logic [1:0]         run_state,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 32'd1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [CYCLE_W-1:0] COUNT_ONE  = CYCLE_W'(1);

    // Synchronizer bit positions: {start, debug, en, m_clk_btn}
    logic [3:0] meta_r;
    logic [3:0] sync_r;
    logic       start_prev_r;

    logic start_s;
    logic debug_s;
    logic en_s;
    logic start_rise_s;
    logic start_fall_s;
    logic btn_level_s;
    logic btn_press_s;

    run_state_t         state_r;
    run_state_t         state_s;
    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_s;
    logic               ce_s;
    logic               start_pulse_s;
    logic [CYCLE_W-1:0] count_s;

    assign start_s      = sync_r[3];
    assign debug_s      = sync_r[2];
    assign en_s         = sync_r[1];
    assign start_rise_s = start_s & ~start_prev_r;
    assign start_fall_s = ~start_s & start_prev_r;
    assign run_state    = state_r;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clock (clock),
        .reset (reset),
        .din   (sync_r[0]),
        .level (btn_level_s),
        .press (btn_press_s)
    );

    // Next state, prescaler and output pulses; start fall beats halt beats mode change beats pulse issue
    always_comb begin
        state_s       = state_r;
        presc_s       = presc_r;
        ce_s          = 1'b0;
        start_pulse_s = 1'b0;
        count_s       = cycle_count;
        case (state_r)
            IDLE: begin
                presc_s = '0;
                if (start_rise_s) begin
                    start_pulse_s = 1'b1;
                    count_s       = '0;
                    state_s       = debug_s ? STEP : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (start_fall_s) begin
                    state_s = IDLE;
                    presc_s = '0;
                end else if (halt_req) begin
                    // a coinciding terminal count is swallowed
                    state_s = HALTED;
                    presc_s = '0;
                end else if (debug_s) begin
                    state_s = STEP;
                    presc_s = '0;
                end else if (en_s) begin
                    if (presc_r == PRESC_LAST) begin
                        presc_s = '0;
                        ce_s    = 1'b1;
                        count_s = cycle_count + COUNT_ONE;
                    end else begin
                        presc_s = presc_r + PRESC_ONE;
                    end
                end else begin
                    // paused: prescaler keeps its value
                    presc_s = presc_r;
                end
            end
            STEP: begin
                presc_s = '0;
                if (start_fall_s) begin
                    state_s = IDLE;
                end else if (halt_req) begin
                    state_s = HALTED;
                end else if (!debug_s) begin
                    state_s = RUN;
                end else if (btn_press_s && btn_level_s && en_s) begin
                    // a press while paused is dropped, not queued
                    ce_s    = 1'b1;
                    count_s = cycle_count + COUNT_ONE;
                end else begin
                    state_s = STEP;
                end
            end
            HALTED: begin
                presc_s = '0;
                if (start_fall_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = HALTED;
                end
            end
            default: begin
                state_s = IDLE;
                presc_s = '0;
            end
        endcase
    end

    // Synchronizers, FSM state, prescaler and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r       <= 4'b0000;
            sync_r       <= 4'b0000;
            start_prev_r <= 1'b0;
            state_r      <= IDLE;
            presc_r      <= '0;
            cpu_ce       <= 1'b0;
            cpu_start    <= 1'b0;
            cycle_count  <= '0;
        end else begin
            meta_r       <= {start, debug, en, m_clk_btn};
            sync_r       <= meta_r;
            start_prev_r <= start_s;
            state_r      <= state_s;
            presc_r      <= presc_s;
            cpu_ce       <= ce_s;
            cpu_start    <= start_pulse_s;
            cycle_count  <= count_s;
        end
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the pipelined CPU on the board top level. It replaces the divided-clock / manual-clock multiplexing with a single-clock scheme: the CPU and memories stay on `clock`, and this block issues one-cycle clock-enable pulses. Pulses come either from a free-running prescaler (auto mode) or from debounced step-button presses (debug mode). It also generates the CPU start pulse, handles halt, and keeps an executed-cycle counter for the seven-segment display.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: `clock` cycles per auto-mode CPU step, so one step per second at 50 MHz. Legal range is 2..2^32-1.
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles needed to accept a step-button level change (10 ms). Legal range is 1..2^20-1.

Ports:
- `clock` in 1: system clock. The block uses this single clock only.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: raw run switch (asynchronous).
- `debug` in 1: raw mode switch (asynchronous). 1 selects single-step mode; 0 selects auto mode.
- `en` in 1: raw enable switch (asynchronous). 0 pauses issue of pulses.
- `m_clk_btn` in 1: raw step pushbutton (asynchronous, bouncy).
- `halt_req` in 1: CPU halt indication, synchronous to `clock`.
- `cpu_ce` out 1: CPU clock enable. It is a one-cycle pulse.
- `cpu_start` out 1: one-cycle pulse that starts/restarts the CPU.
- `run_state` out 2: current FSM state.
- `cycle_count` out 16: number of `cpu_ce` pulses issued since the last start.

## Operation
- **Input synchronisation:** `start`, `debug`, `en` and `m_clk_btn` each pass through a 2-flop synchronizer before any use. `halt_req` is not synchronized.
- **Debounce:** the synchronized `m_clk_btn` feeds `btn_debounce`.
  - The debounced level toggles only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any cycle of agreement clears the stability counter.
  - A rising edge of the debounced level produces a one-cycle `press` strobe.
- **States** (`run_state` encoding): IDLE=0, RUN=1, STEP=2, HALTED=3.
- **IDLE:**
  - On a synchronized `start` rising edge: assert `cpu_start` for one cycle and clear `cycle_count`.
  - Go to STEP if synced `debug`=1, otherwise go to RUN.
- **RUN:**
  - A prescaler counts 0..`TICK_DIV`-1 while synced `en`=1 and holds its value while `en`=0.
  - On the terminal count, `cpu_ce`=1 for that cycle and the prescaler returns to 0.
  - Synced `debug`=1 → go to STEP and clear the prescaler.
- **STEP:**
  - Each `press` with synced `en`=1 gives `cpu_ce`=1 in the following cycle.
  - A `press` with `en`=0 is discarded, not queued.
  - Synced `debug`=0 → go to RUN with the prescaler at 0.
- **HALTED:** no `cpu_ce` is issued. A synced `start` falling edge → go to IDLE.
- **From RUN or STEP:**
  - `halt_req`=1 → go to HALTED.
  - A synced `start` falling edge → go to IDLE.
- **Priority within a cycle, highest first:** reset, then start falling edge, then `halt_req`, then mode change, then pulse issue.
  - If `halt_req` coincides with a terminal count or a pending step, no `cpu_ce` is issued.
  - A pending step is dropped on any state change.
- **Cycle counter:** `cycle_count` increments in the same cycle as each `cpu_ce` and wraps from 0xFFFF to 0x0000. It holds its value in HALTED and IDLE, so the display shows the final count.
- **Guarantees:** `cpu_ce` and `cpu_start` are never high in the same cycle. `cpu_ce` is never high on two consecutive cycles.

## Timing
- **Reset values:**
  - Outputs: `run_state`=IDLE, `cpu_ce`=0, `cpu_start`=0, `cycle_count`=0.
  - Internal state: prescaler, debounce counter, debounced level and all synchronizer flops are 0.
- **Reset mid-operation:** reset in any state returns to IDLE on the next edge and drops any pending step or partial debounce.
- **Outputs are registered.**
- **Start latency:** the `start` pin is first sampled high at edge N → `cpu_start` is high in cycle N+3.
- **Auto period:** with `en` held high, consecutive `cpu_ce` pulses are exactly `TICK_DIV` cycles apart. The first pulse comes `TICK_DIV` cycles after entering RUN.
- **Step latency:** `m_clk_btn` is first sampled high at edge N and held → `cpu_ce` is high in cycle N+`DEBOUNCE_CYCLES`+3. The button must be released and debounced low before the next press counts.
- **Bounce:** glitches shorter than `DEBOUNCE_CYCLES` produce no `press`.

## Structure
- **Shared package `pcpu_ctrl_pkg`:** holds the state encoding constants IDLE/RUN/STEP/HALTED and the `cycle_count` width (16). The display mux and CPU debug logic also use these.
- **Sub-module `btn_debounce`:** parameterised by `DEBOUNCE_CYCLES`; ports `clock`, `reset`, `din`, `level`, `press`. It is reused for any future panel buttons.
- **Synchronizers:** inline 2-flop stages inside `cpu_run_ctrl`.

## Test plan
Benches use `TICK_DIV`=4 and `DEBOUNCE_CYCLES`=3.
- **Auto run:** reset, `debug`=0, `en`=1, raise `start` → `cpu_start` pulse 3 cycles later, then `cpu_ce` every 4 cycles. After 40 cycles in RUN, `cycle_count`=10.
- **Pause:** during RUN, drop `en` for 7 cycles → no `cpu_ce` in that window, and the prescaler resumes from its held value.
- **Step mode:**
  - `debug`=1, clean press held for 10 cycles → exactly one `cpu_ce`, at N+6.
  - Button toggling every 2 cycles → no `cpu_ce`.
- **Halt collision:** `halt_req` asserted on a terminal-count cycle → no `cpu_ce`, `run_state`=3, `cycle_count` frozen. Then drop `start` → `run_state`=0.
- **Wrap:** preload 0xFFFF pulses (reduced by force) → the next `cpu_ce` gives `cycle_count`=0x0000.
- **Reset mid-debounce:** reset 2 cycles into a press → all outputs 0 and `run_state`=0 next cycle, with no spurious `cpu_ce` afterwards.
